// File: rtl/isp_boot_pkg.sv
// Shared FSM encoding and widths for the ISP boot/run sequencer.
package isp_boot_pkg;

    localparam int unsigned STATE_BITS       = 3;
    localparam int unsigned CYCLE_COUNT_BITS = 32;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        RUN,
        FINISH
    } state_t;

endpackage

// File: rtl/isp_boot_ctrl.sv
// Streams instruction words into core program memory over the ISP port,
// then starts the core at the session entry address and supervises the run.
module isp_boot_ctrl
    import isp_boot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_BITS   = 12,
    parameter int unsigned PROG_ADDR_BITS = 20,
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_req,
    input  logic [ADDRESS_BITS-1:0]     load_base,
    input  logic [ADDRESS_BITS:0]       load_count,
    input  logic [PROG_ADDR_BITS-1:0]   entry_address,
    input  logic                        word_valid,
    input  logic [DATA_WIDTH-1:0]       word_data,
    output logic                        word_ready,
    output logic                        isp_write,
    output logic [ADDRESS_BITS-1:0]     isp_address,
    output logic [DATA_WIDTH-1:0]       isp_data,
    output logic                        core_start,
    output logic [PROG_ADDR_BITS-1:0]   core_prog_address,
    input  logic                        run_done,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        timed_out,
    output logic [CYCLE_COUNT_BITS-1:0] cycle_count
);

    state_t state;
    state_t state_next;

    logic [ADDRESS_BITS-1:0] base_q;
    logic [ADDRESS_BITS:0]   count_q;
    logic [ADDRESS_BITS:0]   index_q;
    logic                    handshake;
    logic                    last_word;
    logic                    timeout_hit;

    assign handshake   = word_valid && word_ready;
    assign last_word   = (index_q == count_q - (ADDRESS_BITS+1)'(1));
    // cycle_count still holds the previous RUN cycle, so the current one is cycle_count+1
    assign timeout_hit = (cycle_count >= CYCLE_COUNT_BITS'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_req) state_next = (load_count != '0) ? LOAD : START;
            LOAD:    if (handshake && last_word) state_next = FLUSH;
            FLUSH:   state_next = START;
            START:   state_next = RUN;
            RUN:     if (run_done || timeout_hit) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) state_next = IDLE;
    end

    // Strobes are registered from the next state so each lines up with its state cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_ready        <= 1'b0;
            isp_write         <= 1'b0;
            isp_address       <= '0;
            isp_data          <= '0;
            core_start        <= 1'b0;
            core_prog_address <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            timed_out         <= 1'b0;
            cycle_count       <= '0;
            base_q            <= '0;
            count_q           <= '0;
            index_q           <= '0;
        end else begin
            word_ready <= (state_next == LOAD);
            core_start <= (state_next == START);
            busy       <= (state_next != IDLE);
            done       <= (state_next == FINISH);
            isp_write  <= handshake;

            if (handshake) begin
                isp_address <= base_q + index_q[ADDRESS_BITS-1:0];
                isp_data    <= word_data;
                index_q     <= index_q + (ADDRESS_BITS+1)'(1);
            end

            unique case (state)
                IDLE: begin
                    if (load_req) begin
                        base_q            <= load_base;
                        count_q           <= load_count;
                        core_prog_address <= entry_address;
                        index_q           <= '0;
                        timed_out         <= 1'b0;
                        cycle_count       <= '0;
                    end
                end
                START: cycle_count <= '0;
                RUN: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_COUNT_BITS'(1);
                    if ((state_next == FINISH) && !run_done) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_isp_boot_ctrl.sv
// Randomized session bench for isp_boot_ctrl checked against a cycle-numbered session model.
module tb_isp_boot_ctrl;

    localparam int T = 100;

    logic        clock;
    logic        reset;
    logic        load_req;
    logic [11:0] load_base;
    logic [12:0] load_count;
    logic [19:0] entry_address;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        isp_write;
    logic [11:0] isp_address;
    logic [31:0] isp_data;
    logic        core_start;
    logic [19:0] core_prog_address;
    logic        run_done;
    logic        abort;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;

    int vectors;
    int miscompares;

    isp_boot_ctrl #(
        .DATA_WIDTH     (32),
        .ADDRESS_BITS   (12),
        .PROG_ADDR_BITS (20),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .load_req          (load_req),
        .load_base         (load_base),
        .load_count        (load_count),
        .entry_address     (entry_address),
        .word_valid        (word_valid),
        .word_data         (word_data),
        .word_ready        (word_ready),
        .isp_write         (isp_write),
        .isp_address       (isp_address),
        .isp_data          (isp_data),
        .core_start        (core_start),
        .core_prog_address (core_prog_address),
        .run_done          (run_done),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .timed_out         (timed_out),
        .cycle_count       (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, word_ready, 0);
        check({tag, "_write"}, isp_write, 0);
        check({tag, "_addr"},  isp_address, 0);
        check({tag, "_data"},  isp_data, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_entry"}, core_prog_address, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_tout"},  timed_out, 0);
        check({tag, "_ccnt"},  cycle_count, 0);
    endtask

    // Cycle k=0 is the load_req cycle. mode: 0 back-to-back, 1 valid every other cycle,
    // 2 random. d: RUN cycle number of run_done (0 = never). abort_run: RUN cycle
    // carrying abort together with run_done (0 = none).
    task automatic run_session(input logic [11:0] base, input int count, input logic [19:0] entry,
                               input int mode, input bit fixed, input int d, input int abort_run);
        int          acc;
        int          start_cyc;
        int          end_cyc;
        int          fin_cyc;
        int          exp_cc;
        int          j;
        int          limit;
        bit          prev_acc;
        bit          aborted;
        bit          exp_to;
        bit          finished;
        bit          in_run;
        bit          exp_ready;
        bit          acc_now;
        logic [11:0] prev_addr;
        logic [31:0] prev_data;

        acc       = 0;
        start_cyc = (count == 0) ? 1 : -1;
        end_cyc   = -1;
        fin_cyc   = -1;
        exp_cc    = 0;
        prev_acc  = 0;
        aborted   = 0;
        exp_to    = 0;
        finished  = 0;
        prev_addr = '0;
        prev_data = '0;
        limit     = 4 * count + 2 * T + 20;

        for (int k = 0; k < limit && !finished; k++) begin
            @(negedge clock);
            exp_ready = (k >= 1) && (acc < count) && !aborted;
            check("word_ready", word_ready, exp_ready);
            check("isp_write", isp_write, prev_acc);
            if (prev_acc) begin
                check("isp_address", isp_address, prev_addr);
                check("isp_data", isp_data, prev_data);
            end
            check("core_start", core_start, (k == start_cyc) && !aborted);
            if (k == start_cyc) check("core_prog_address", core_prog_address, entry);
            check("busy", busy, (k >= 1) && (end_cyc < 0 || k <= end_cyc));
            check("done", done, k == fin_cyc);

            if (end_cyc >= 0 && k == end_cyc + 1) begin
                finished   = 1;
                load_req   = 0;
                word_valid = 0;
                run_done   = 0;
                abort      = 0;
                check("timed_out", timed_out, aborted ? 1'b0 : exp_to);
                if (!aborted) check("cycle_count", cycle_count, exp_cc);
                check("entry_hold", core_prog_address, entry);
            end else begin
                load_req = (k == 0);
                if (k == 0) begin
                    load_base     = base;
                    load_count    = 13'(count);
                    entry_address = entry;
                end
                j      = (start_cyc >= 0) ? k - start_cyc : 0;
                in_run = (start_cyc >= 0) && (j >= 1) && (end_cyc < 0);
                if (in_run && j == 1) begin
                    load_req      = 1;
                    load_base     = ~base;
                    load_count    = 13'd5;
                    entry_address = ~entry;
                end

                case (mode)
                    0:       word_valid = 1;
                    1:       word_valid = (k % 2 == 1);
                    default: word_valid = 1'($urandom_range(0, 1));
                endcase
                word_data = fixed ? 32'hAAAA0001 + 32'(acc) : $urandom;

                acc_now  = exp_ready && word_valid;
                prev_acc = acc_now;
                if (acc_now) begin
                    prev_addr = base + 12'(acc);
                    prev_data = word_data;
                    acc++;
                    if (acc == count) start_cyc = k + 2;
                end

                run_done = in_run && (j == d || j == abort_run);
                abort    = in_run && (abort_run != 0) && (j == abort_run);
                if (in_run) begin
                    if (abort_run != 0 && j == abort_run) begin
                        aborted = 1;
                        end_cyc = k;
                    end else if (j == d || j == T) begin
                        fin_cyc = k + 1;
                        end_cyc = k + 1;
                        exp_cc  = j;
                        exp_to  = (j != d);
                    end
                end
            end
        end
        check("session_bound", finished, 1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1;
        load_req      = 0;
        load_base     = '0;
        load_count    = '0;
        entry_address = '0;
        word_valid    = 0;
        word_data     = '0;
        run_done      = 0;
        abort         = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 0;

        run_session(12'h010, 3, 20'h00010, 0, 1, 5, 0);
        run_session(12'h010, 3, 20'h00010, 1, 1, 7, 0);
        run_session(12'hFFE, 3, 20'h0ABCD, 2, 0, 2, 0);
        run_session(12'h300, 0, 20'h12345, 0, 0, 0, 0);
        run_session(12'h040, 2, 20'h00200, 0, 0, 3, 3);
        run_session(12'h050, 1, 20'h00300, 2, 0, T, 0);

        // Reset while loading word 3 of 4.
        @(negedge clock);
        load_req      = 1;
        load_base     = 12'h100;
        load_count    = 13'd4;
        entry_address = 20'h00400;
        @(negedge clock);
        load_req   = 0;
        word_valid = 1;
        word_data  = $urandom;
        @(negedge clock);
        word_data = $urandom;
        @(negedge clock);
        check("midload_write", isp_write, 1);
        check("midload_busy", busy, 1);
        word_valid = 0;
        #2 reset = 1;
        #1;
        check_all_zero("midload_reset");
        @(negedge clock);
        reset = 0;
        run_session(12'h020, 4, 20'h00020, 0, 0, 4, 0);

        for (int s = 0; s < 4; s++) begin
            run_session(12'($urandom), int'($urandom_range(1, 8)), 20'($urandom), 2, 0,
                        int'($urandom_range(1, 130)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/isp_boot_ctrl.md
Name: isp_boot_ctrl

Overview:
Sequences a RISC_V_Core through a load-and-run session. It accepts a stream of instruction words over a valid/ready handshake and writes them into program memory through the core's isp_write/isp_address/isp_data port. It then pulses start with the session's entry prog_address and supervises execution until the core signals completion or a cycle budget expires. It sits between a host/loader stream and one core instance, replacing hand-driven start/prog_address/isp stimulus.

Parameters:
DATA_WIDTH, 32, instruction word and isp_data width
ADDRESS_BITS, 12, isp_address width (word-indexed program memory)
PROG_ADDR_BITS, 20, width of core prog_address
TIMEOUT_CYCLES, 100, maximum RUN cycles before forced finish (>=1)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
load_req  in  1  start a session (sampled only in IDLE)
load_base  in  ADDRESS_BITS  first isp address, latched on load_req
load_count  in  ADDRESS_BITS+1  number of words to load, latched; 0 = no load
entry_address  in  PROG_ADDR_BITS  prog_address for the core, latched on load_req
word_valid  in  1  stream word valid
word_data  in  DATA_WIDTH  stream word
word_ready  out  1  block accepts a word
isp_write  out  1  program-memory write strobe to core
isp_address  out  ADDRESS_BITS  write address
isp_data  out  DATA_WIDTH  write data
core_start  out  1  one-cycle start pulse to core
core_prog_address  out  PROG_ADDR_BITS  prog_address to core
run_done  in  1  core completion indication
abort  in  1  cancel session
busy  out  1  state != IDLE
done  out  1  one-cycle session-complete pulse
timed_out  out  1  last session ended by timeout
cycle_count  out  32  RUN cycles of last/current session

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched base/count/entry/index cleared.
- All outputs registered; all state changes on rising clock.
- IDLE: word_ready=0. If load_req=1, latch base, count and entry, clear index. Go to LOAD if count!=0, else START. Clear timed_out and cycle_count.
- LOAD: word_ready=1. A handshake (word_valid&word_ready) in cycle k drives isp_write=1, isp_address=base+index (mod 2^ADDRESS_BITS, wraps), isp_data=word_data in cycle k+1 only; index increments. isp_write=0 in cycles without a handshake.
  - The handshake of word count-1 moves to FLUSH; word_ready is 0 in FLUSH.
- FLUSH: one cycle; the final isp_write occurs here. Go to START.
- START: core_start=1 for exactly this cycle. core_prog_address=entry, driven from the load_req latch until the next session. cycle_count cleared. Go to RUN.
- RUN: cycle_count increments each cycle (saturates at 2^32-1).
  - run_done=1 goes to FINISH with timed_out=0.
  - If the RUN cycle number reaches TIMEOUT_CYCLES without run_done, go to FINISH with timed_out=1.
  - run_done on the timeout cycle wins (timed_out=0). cycle_count equals the number of RUN cycles, including the terminating one.
- FINISH: done=1 for one cycle. Go to IDLE. timed_out and cycle_count hold until the next accepted load_req.
- abort=1 in any non-IDLE state: next state IDLE, no done, any pending isp_write still issues, core_start suppressed. Abort beats run_done and timeout.
- load_req outside IDLE is ignored.
- busy=1 whenever state!=IDLE.
- Latency, back-to-back words, load_req in cycle 0, count=N:
  - word_ready from cycle 1
  - writes in cycles 2..N+1 (FLUSH = N+1)
  - core_start in cycle N+2
  - first RUN cycle N+3
- Latency, count=0: core_start in cycle 1.

Decomposition:
- Shared package isp_boot_pkg holds:
  - state encoding (IDLE, LOAD, FLUSH, START, RUN, FINISH; 3 bits)
  - the STATE_BITS constant
  - the cycle_count width constant (32)
- No sub-module required. Single FSM plus index, cycle counter and output registers; about 200 lines.

Test Plan:
- Load 3 words (0xAAAA0001, 0xAAAA0002, 0xAAAA0003), base 0x010, entry 0x00010, back-to-back valid, run_done at 5th RUN cycle -> isp writes 0x010/0x011/0x012 in cycles 2-4; core_start in cycle 5 with core_prog_address=0x00010; done pulse; cycle_count=5, timed_out=0.
- Same load with word_valid low every other cycle -> exactly 3 isp_write pulses at consecutive addresses, no duplicates; core_start 1 cycle after last write.
- Wrap: base 0xFFE, count 3 -> isp_address 0xFFE, 0xFFF, 0x000.
- count=0, run_done never asserted, TIMEOUT_CYCLES=100 -> core_start in cycle 1; done 100 RUN cycles later; timed_out=1, cycle_count=100.
- run_done and abort same cycle in RUN -> IDLE, no done pulse, busy=0 next cycle. Load_req during RUN is ignored.
- reset asserted mid-LOAD after 2 of 4 words -> all outputs 0 immediately. New session from base 0x020 writes from index 0.
